arb_mux: RTL and testbench

ARB_MUX -- requirements
Module: arb_mux

---
 rtl/arb_mux.sv | 107 ++++++++++
 tb/tb_arb_mux.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/arb_mux.sv
// Multi-channel valid/ready multiplexer with one registered output stage.
// MODE 0 selects the channel named by sel; MODE 1 arbitrates round-robin.
module arb_mux #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned N     = 4,
  parameter int unsigned MODE  = 0,
  localparam int unsigned SEL_W = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         in_valid,
  input  logic [N*WIDTH-1:0]   in_data,
  output logic [N-1:0]         in_ready,
  input  logic [SEL_W-1:0]     sel,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     out_data,
  output logic [SEL_W-1:0]     out_sel,
  input  logic                 out_ready
);

  logic              load;
  logic              gnt_valid;
  logic [SEL_W-1:0]  gnt;
  logic [WIDTH-1:0]  gnt_data;
  logic              xfer;

  logic              out_valid_q, out_valid_d;
  logic [WIDTH-1:0]  out_data_q, out_data_d;
  logic [SEL_W-1:0]  out_sel_q, out_sel_d;
  logic [SEL_W-1:0]  ptr_q, ptr_d;

  assign load = !out_valid_q || out_ready;

  // Candidate channel: sel in MODE 0, first valid at or after ptr in MODE 1.
  always_comb begin
    int unsigned idx;
    idx       = 0;
    gnt       = '0;
    gnt_valid = 1'b0;
    if (MODE == 0) begin
      gnt       = sel;
      gnt_valid = (32'(sel) < N);
    end else begin
      for (int unsigned k = 0; k < N; k++) begin
        idx = (32'(ptr_q) + k) % N;
        if (!gnt_valid && in_valid[SEL_W'(idx)]) begin
          gnt_valid = 1'b1;
          gnt       = SEL_W'(idx);
        end
      end
    end
  end

  always_comb begin
    gnt_data = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (gnt == SEL_W'(i)) begin
        gnt_data = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    in_ready = '0;
    if (!rst && gnt_valid && load) begin
      in_ready[gnt] = 1'b1;
    end
  end

  assign xfer = |(in_valid & in_ready);

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    ptr_d       = ptr_q;
    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = gnt_data;
      out_sel_d   = gnt;
      if (MODE != 0) begin
        ptr_d = (gnt == SEL_W'(N - 1)) ? '0 : gnt + SEL_W'(1);
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      ptr_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_arb_mux.sv
// Directed bench for arb_mux: MODE 0 (N=4), MODE 1 round-robin (N=4), MODE 0 with N=3.
module tb_arb_mux;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // MODE 0, N=4
  logic         m0_rst, m0_ordy, m0_ov;
  logic [3:0]   m0_iv, m0_ir;
  logic [127:0] m0_data;
  logic [1:0]   m0_sel, m0_osel;
  logic [31:0]  m0_od;

  // MODE 1, N=4
  logic         rr_rst, rr_ordy, rr_ov;
  logic [3:0]   rr_iv, rr_ir;
  logic [127:0] rr_data;
  logic [1:0]   rr_sel, rr_osel;
  logic [31:0]  rr_od;

  // MODE 0, N=3
  logic         n3_rst, n3_ordy, n3_ov;
  logic [2:0]   n3_iv, n3_ir;
  logic [95:0]  n3_data;
  logic [1:0]   n3_sel, n3_osel;
  logic [31:0]  n3_od;

  arb_mux #(.WIDTH(32), .N(4), .MODE(0)) u_m0 (
    .clk(clk), .rst(m0_rst), .in_valid(m0_iv), .in_data(m0_data), .in_ready(m0_ir),
    .sel(m0_sel), .out_valid(m0_ov), .out_data(m0_od), .out_sel(m0_osel), .out_ready(m0_ordy)
  );

  arb_mux #(.WIDTH(32), .N(4), .MODE(1)) u_rr (
    .clk(clk), .rst(rr_rst), .in_valid(rr_iv), .in_data(rr_data), .in_ready(rr_ir),
    .sel(rr_sel), .out_valid(rr_ov), .out_data(rr_od), .out_sel(rr_osel), .out_ready(rr_ordy)
  );

  arb_mux #(.WIDTH(32), .N(3), .MODE(0)) u_n3 (
    .clk(clk), .rst(n3_rst), .in_valid(n3_iv), .in_data(n3_data), .in_ready(n3_ir),
    .sel(n3_sel), .out_valid(n3_ov), .out_data(n3_od), .out_sel(n3_osel), .out_ready(n3_ordy)
  );

  typedef struct {
    logic        rst;
    logic [3:0]  iv;
    logic        ordy;
    logic [3:0]  exp_ir;
    logic        exp_ov;
    logic [1:0]  exp_sel;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs[22];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic m0_cycle(input string tag, input logic r, input logic [1:0] s,
                          input logic [3:0] iv, input logic ordy, input logic [3:0] eir,
                          input logic eov, input logic [1:0] esel, input logic [31:0] edata);
    m0_rst = r; m0_sel = s; m0_iv = iv; m0_ordy = ordy;
    @(negedge clk);
    check({tag, " in_ready"}, 64'(m0_ir), 64'(eir));
    @(posedge clk); #1;
    check({tag, " out_valid"}, 64'(m0_ov), 64'(eov));
    check({tag, " out_sel"}, 64'(m0_osel), 64'(esel));
    check({tag, " out_data"}, 64'(m0_od), 64'(edata));
  endtask

  task automatic n3_cycle(input string tag, input logic [1:0] s, input logic [2:0] eir,
                          input logic eov, input logic [1:0] esel, input logic [31:0] edata);
    n3_rst = 1'b0; n3_sel = s; n3_iv = 3'b111; n3_ordy = 1'b1;
    @(negedge clk);
    check({tag, " in_ready"}, 64'(n3_ir), 64'(eir));
    @(posedge clk); #1;
    check({tag, " out_valid"}, 64'(n3_ov), 64'(eov));
    check({tag, " out_sel"}, 64'(n3_osel), 64'(esel));
    check({tag, " out_data"}, 64'(n3_od), 64'(edata));
  endtask

  localparam logic [31:0] D0 = 32'hD000_0000;
  localparam logic [31:0] D1 = 32'hD000_0001;
  localparam logic [31:0] D2 = 32'hD000_0002;
  localparam logic [31:0] D3 = 32'hD000_0003;

  initial begin
    // round-robin table: one row per cycle
    vecs[0]  = '{1'b1, 4'b1111, 1'b1, 4'b0000, 1'b0, 2'd0, 32'h0};
    vecs[1]  = '{1'b0, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, D0};
    vecs[2]  = '{1'b0, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, D1};
    vecs[3]  = '{1'b0, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, D2};
    vecs[4]  = '{1'b0, 4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3, D3};
    vecs[5]  = '{1'b0, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, D0};
    vecs[6]  = '{1'b0, 4'b0110, 1'b1, 4'b0010, 1'b1, 2'd1, D1};
    vecs[7]  = '{1'b0, 4'b0100, 1'b1, 4'b0100, 1'b1, 2'd2, D2};
    vecs[8]  = '{1'b0, 4'b0011, 1'b1, 4'b0001, 1'b1, 2'd0, D0};
    vecs[9]  = '{1'b0, 4'b0011, 1'b1, 4'b0010, 1'b1, 2'd1, D1};
    vecs[10] = '{1'b0, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, D2};
    vecs[11] = '{1'b0, 4'b1111, 1'b0, 4'b0000, 1'b1, 2'd2, D2};
    vecs[12] = '{1'b0, 4'b1111, 1'b0, 4'b0000, 1'b1, 2'd2, D2};
    vecs[13] = '{1'b0, 4'b1111, 1'b0, 4'b0000, 1'b1, 2'd2, D2};
    vecs[14] = '{1'b0, 4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3, D3};
    vecs[15] = '{1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd3, D3};
    vecs[16] = '{1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd3, D3};
    vecs[17] = '{1'b0, 4'b1111, 1'b0, 4'b0001, 1'b1, 2'd0, D0};
    vecs[18] = '{1'b0, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, D1};
    vecs[19] = '{1'b1, 4'b1111, 1'b0, 4'b0000, 1'b0, 2'd0, 32'h0};
    vecs[20] = '{1'b0, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, D0};
    vecs[21] = '{1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, D0};

    m0_rst = 1'b1; m0_sel = '0; m0_iv = '0; m0_ordy = 1'b1;
    m0_data = {32'h0000_0033, 32'h0000_00C2, 32'hAAAA_5555, 32'h0000_0011};
    rr_rst = 1'b1; rr_sel = '0; rr_iv = '0; rr_ordy = 1'b1;
    rr_data = {D3, D2, D1, D0};
    n3_rst = 1'b1; n3_sel = '0; n3_iv = '0; n3_ordy = 1'b1;
    n3_data = {32'h0000_0302, 32'h0000_0301, 32'h0000_0300};

    @(posedge clk); #1;
    check("m0 reset out_valid", 64'(m0_ov), 64'd0);
    check("m0 reset out_data", 64'(m0_od), 64'd0);
    check("n3 reset out_valid", 64'(n3_ov), 64'd0);

    // direct select
    m0_cycle("m0 sel2",      1'b0, 2'd2, 4'b0100, 1'b1, 4'b0100, 1'b1, 2'd2, 32'h0000_00C2);
    m0_cycle("m0 sel3 idle", 1'b0, 2'd3, 4'b0000, 1'b1, 4'b1000, 1'b0, 2'd2, 32'h0000_00C2);
    m0_cycle("m0 sel1 load", 1'b0, 2'd1, 4'b0010, 1'b0, 4'b0010, 1'b1, 2'd1, 32'hAAAA_5555);
    for (int i = 0; i < 3; i++) begin
      m0_cycle($sformatf("m0 stall%0d", i), 1'b0, 2'(i), 4'b1111, 1'b0, 4'b0000, 1'b1, 2'd1,
               32'hAAAA_5555);
    end
    m0_cycle("m0 release",   1'b0, 2'd3, 4'b1000, 1'b1, 4'b1000, 1'b1, 2'd3, 32'h0000_0033);
    m0_cycle("m0 drain",     1'b0, 2'd0, 4'b0000, 1'b1, 4'b0001, 1'b0, 2'd3, 32'h0000_0033);
    m0_cycle("m0 prep",      1'b0, 2'd2, 4'b0100, 1'b0, 4'b0100, 1'b1, 2'd2, 32'h0000_00C2);
    m0_cycle("m0 rst held",  1'b1, 2'd2, 4'b1111, 1'b1, 4'b0000, 1'b0, 2'd0, 32'h0);
    m0_rst = 1'b1;

    // round-robin table
    for (int i = 0; i < 22; i++) begin
      rr_rst = vecs[i].rst; rr_iv = vecs[i].iv; rr_ordy = vecs[i].ordy;
      @(negedge clk);
      check($sformatf("rr[%0d] in_ready", i), 64'(rr_ir), 64'(vecs[i].exp_ir));
      @(posedge clk); #1;
      check($sformatf("rr[%0d] out_valid", i), 64'(rr_ov), 64'(vecs[i].exp_ov));
      check($sformatf("rr[%0d] out_sel", i), 64'(rr_osel), 64'(vecs[i].exp_sel));
      check($sformatf("rr[%0d] out_data", i), 64'(rr_od), 64'(vecs[i].exp_data));
    end
    rr_rst = 1'b1;

    // N=3: sel beyond the last channel must not transfer
    n3_cycle("n3 sel3",    2'd3, 3'b000, 1'b0, 2'd0, 32'h0);
    n3_cycle("n3 sel2",    2'd2, 3'b100, 1'b1, 2'd2, 32'h0000_0302);
    n3_cycle("n3 sel3 b",  2'd3, 3'b000, 1'b0, 2'd2, 32'h0000_0302);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
